// File: rtl/io_mmio_controller.sv
// MMIO block for the MIPS data bus: debounced BTNL/BTNR handshake flags,
// switch snapshot, display register and a scanned 8-digit seven-segment output.
module io_mmio_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        btnl,
  input  logic        btnr,
  input  logic [15:0] sw,
  output logic [7:0]  an,
  output logic        dp,
  output logic [6:0]  a2g
);

  localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);

  // bit 0 = btnl (display ready), bit 1 = btnr (switch ready)
  logic [1:0]      sync1, sync2, stable, press;
  logic [DB_W-1:0] db_cnt [2];

  logic        sw_ready, disp_ready;
  logic [15:0] sw_snap;
  logic [31:0] disp_reg;

  logic [SC_W-1:0] scan_cnt;
  logic [2:0]      idx, idx_next;

  logic sel_status, sel_switch, sel_display;
  logic unused_addr_lsbs;

  assign sel_status  = addr[7] && (addr[6:2] == 5'd0);
  assign sel_switch  = addr[7] && (addr[6:2] == 5'd2);
  assign sel_display = addr[7] && (addr[6:2] == 5'd3);
  assign unused_addr_lsbs = ^addr[1:0];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // press is registered on the same edge the stable level rises
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btnr, btnl};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= ~stable[i];
          press[i]  <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Flag sets take priority over any clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_ready   <= 1'b0;
      disp_ready <= 1'b0;
      sw_snap    <= '0;
      disp_reg   <= '0;
    end else begin
      if (press[1]) begin
        sw_ready <= 1'b1;
        sw_snap  <= sw;
      end else if (we && sel_status && wdata[1]) begin
        sw_ready <= 1'b0;
      end
      if (press[0])
        disp_ready <= 1'b1;
      else if (we && ((sel_status && wdata[0]) || sel_display))
        disp_ready <= 1'b0;
      if (we && sel_display)
        disp_reg <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_status)       rdata = {30'b0, sw_ready, disp_ready};
    else if (sel_switch)  rdata = {16'b0, sw_snap};
    else if (sel_display) rdata = disp_reg;
  end

  assign idx_next = (scan_cnt == SC_MAX) ? idx + 3'd1 : idx;

  // an/a2g are registered from idx_next so they move on the same edge as idx
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 8'hFE;
      a2g      <= 7'h40;
    end else begin
      scan_cnt <= (scan_cnt == SC_MAX) ? '0 : scan_cnt + SC_W'(1);
      idx      <= idx_next;
      an       <= ~(8'b1 << idx_next);
      a2g      <= seg7(disp_reg[{idx_next, 2'b00} +: 4]);
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_io_mmio_controller.sv
// Directed bench for io_mmio_controller with short debounce/scan parameters.
module tb_io_mmio_controller;

  logic        clk = 0;
  logic        reset = 0;
  logic        we = 0;
  logic [7:0]  addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic        btnl = 0, btnr = 0;
  logic [15:0] sw = 0;
  logic [7:0]  an;
  logic        dp;
  logic [6:0]  a2g;

  int checks = 0;
  int failures = 0;

  io_mmio_controller #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .btnl(btnl), .btnr(btnr), .sw(sw), .an(an), .dp(dp), .a2g(a2g)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1;
    @(posedge clk);
    #1;
    we = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    do_reset();
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0); end
    rd(8'h88, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_switch got=%h exp=%h", d, 32'h0); end
    rd(8'h8C, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_display got=%h exp=%h", d, 32'h0); end
    checks++;
    if (an !== 8'hFE || a2g !== 7'h40 || dp !== 1'b1) begin
      failures++; $display("FAIL reset_outputs got an=%h a2g=%h dp=%b exp an=fe a2g=40 dp=1", an, a2g, dp);
    end
  endtask

  task automatic test_switch;
    logic [31:0] d;
    sw = 16'hBEEF; btnr = 1;
    tick(10);
    btnr = 0;
    rd(8'h80, d); checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL sw_ready_set got=%h exp=%h", d, 32'h2); end
    rd(8'h88, d); checks++;
    if (d !== 32'h0000BEEF) begin failures++; $display("FAIL sw_snap got=%h exp=%h", d, 32'h0000BEEF); end
    sw = 16'h1234;
    tick(10);
    rd(8'h88, d); checks++;
    if (d !== 32'h0000BEEF) begin failures++; $display("FAIL sw_snap_hold got=%h exp=%h", d, 32'h0000BEEF); end
    wr(8'h80, 32'h2);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL sw_ready_w1c got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_display_flag;
    logic [31:0] d;
    btnl = 1; tick(2); btnl = 0;
    tick(10);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL glitch_no_pulse got=%h exp=%h", d, 32'h0); end
    btnl = 1; tick(8);
    rd(8'h80, d); checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL disp_ready_set got=%h exp=%h", d, 32'h1); end
    wr(8'h80, 32'h1);
    btnl = 0; tick(10);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL no_release_pulse got=%h exp=%h", d, 32'h0); end
    btnl = 1; tick(8); btnl = 0; tick(10);
    wr(8'h8C, 32'hFEDC_BA98);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL display_write_clears got=%h exp=%h", d, 32'h0); end
    rd(8'h8C, d); checks++;
    if (d !== 32'hFEDCBA98) begin failures++; $display("FAIL display_readback got=%h exp=%h", d, 32'hFEDCBA98); end
    wr(8'h84, 32'h1234_5678);
    rd(8'h84, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); end
    rd(8'h8C, d); checks++;
    if (d !== 32'hFEDCBA98) begin failures++; $display("FAIL unmapped_write got=%h exp=%h", d, 32'hFEDCBA98); end
  endtask

  task automatic test_scan;
    logic [7:0] prev, exp_an;
    logic [6:0] exp_seg;
    bit found;
    wr(8'h8C, 32'h0000_00F1);
    found = 0;
    prev = an;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (an == 8'hFE && prev == 8'h7F) found = 1;
      else prev = an;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL scan_align got=timeout exp=an 7f->fe");
    end else begin
      for (int i = 0; i < 17; i++) begin
        if (i > 0) tick();
        exp_an = ~(8'b1 << ((i / 2) % 8));
        case ((i / 2) % 8)
          0: exp_seg = 7'h79;
          1: exp_seg = 7'h0E;
          default: exp_seg = 7'h40;
        endcase
        checks++;
        if (an !== exp_an || a2g !== exp_seg || dp !== 1'b1) begin
          failures++;
          $display("FAIL scan_step%0d got an=%h a2g=%h dp=%b exp an=%h a2g=%h dp=1", i, an, a2g, dp, exp_an, exp_seg);
        end
      end
    end
  endtask

  task automatic test_set_clear_collision;
    logic [31:0] d;
    btnl = 1;
    tick(6);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL collision_pre got=%h exp=%h", d, 32'h0); end
    addr = 8'h80; wdata = 32'h1; we = 1;
    @(posedge clk);
    #1;
    we = 0;
    btnl = 0;
    rd(8'h80, d); checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL set_beats_clear got=%h exp=%h", d, 32'h1); end
    tick(10);
  endtask

  task automatic test_reset_midway;
    logic [31:0] d;
    do_reset();
    tick(6);
    btnr = 1;
    tick(4);
    checks++;
    if (an !== 8'hDF) begin failures++; $display("FAIL pre_reset_idx5 got=%h exp=%h", an, 8'hDF); end
    reset = 1; btnr = 0;
    tick();
    reset = 0;
    checks++;
    if (an !== 8'hFE || a2g !== 7'h40) begin
      failures++; $display("FAIL reset_scan got an=%h a2g=%h exp an=fe a2g=40", an, a2g);
    end
    tick(10);
    rd(8'h80, d); checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_debounce got=%h exp=%h", d, 32'h0); end
  endtask

  initial begin
    tick();
    test_reset();
    test_switch();
    test_display_flag();
    test_scan();
    test_set_clear_collision();
    test_reset_midway();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
